// File: rtl/io_mem_responder_pkg.sv
// Shared widths and defaults for the IO memory responder.
// DATA_WIDTH / ADDR_BITS defaults are macros so other blocks can share them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 10
`endif

package io_mem_responder_pkg;

    localparam int unsigned DefDataWidth   = `DATA_WIDTH;
    localparam int unsigned DefAddrBits    = `ADDR_BITS;
    localparam int unsigned DefReadLatency = 2;

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read pipeline: each stage holds a valid bit, a data word and an error bit.
// The last stage is the registered read port; its data only changes when a valid read lands.
module mem_rd_pipe
    import io_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned READ_LATENCY = DefReadLatency
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [READ_LATENCY-1:0] valid_q, valid_d;
    logic [READ_LATENCY-1:0] err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_d [READ_LATENCY];
    logic                    unused_last_err;

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = in_valid;
        err_d      = err_q << 1;
        err_d[0]   = in_err;
        data_d     = data_q;
        // Out-of-range reads are zeroed as they enter the output stage.
        if (in_valid) begin
            data_d[0] = (READ_LATENCY == 1 && in_err) ? '0 : in_data;
        end
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            if (valid_q[i-1]) begin
                data_d[i] = (i == READ_LATENCY - 1 && err_q[i-1]) ? '0 : data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign out_valid       = valid_q[READ_LATENCY-1];
    assign out_data        = data_q[READ_LATENCY-1];
    assign unused_last_err = err_q[READ_LATENCY-1];

endmodule

// File: rtl/io_mem_responder.sv
// Single-port word memory answering a memory controller: one request per cycle,
// fixed read latency, out-of-range accesses flagged on mem_err one cycle later.
module io_mem_responder
    import io_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned ADDR_BITS    = DefAddrBits,
    parameter int unsigned READ_LATENCY = DefReadLatency
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] mem_r_data,
    output logic                  mem_r_valid,
    output logic                  mem_err
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [ADDR_BITS-1:0]  word_idx;
    logic                  in_range;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  err_d, err_q;

    always_comb begin
        word_idx = mem_addr[ADDR_BITS-1:0];
        in_range = ~|mem_addr[DATA_WIDTH-1:ADDR_BITS];
        // Storage has no reset, so writes seen while rst is high must be dropped here.
        wr_en    = mem_w_en & in_range & ~rst;
        rd_word  = mem_q[word_idx];
        err_d    = (mem_r_en | mem_w_en) & ~in_range;
    end

    // Read data is taken before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= mem_w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (mem_r_en),
        .in_err   (~in_range),
        .in_data  (rd_word),
        .out_valid(mem_r_valid),
        .out_data (mem_r_data)
    );

    assign mem_err = err_q;

endmodule

// File: tb/tb_io_mem_responder.sv
// Bench for io_mem_responder: three instances (latency 1, 2, 4) share one stimulus stream
// and are checked every cycle against a cycle-indexed expectation model.
module tb_io_mem_responder;

    localparam int unsigned DW = 32;
    localparam int          N  = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_w_data = '0;
    logic          mem_r_en = 1'b0;
    logic          mem_w_en = 1'b0;

    logic [DW-1:0] rd_l1, rd_l2, rd_l4;
    logic          rv_l1, rv_l2, rv_l4;
    logic          er_l1, er_l2, er_l4;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    io_mem_responder #(.DATA_WIDTH(DW), .ADDR_BITS(10), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_r_data(rd_l1), .mem_r_valid(rv_l1), .mem_err(er_l1)
    );
    io_mem_responder #(.DATA_WIDTH(DW), .ADDR_BITS(10), .READ_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_r_data(rd_l2), .mem_r_valid(rv_l2), .mem_err(er_l2)
    );
    io_mem_responder #(.DATA_WIDTH(DW), .ADDR_BITS(10), .READ_LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_r_data(rd_l4), .mem_r_valid(rv_l4), .mem_err(er_l4)
    );

    // Model: memory contents plus per-cycle expected pulses, indexed by clock edge count.
    int            lat [3] = '{1, 2, 4};
    bit            exp_v [3][N];
    logic [DW-1:0] exp_d [3][N];
    bit            exp_e [N];
    logic [DW-1:0] last_d [3] = '{default: '0};
    logic [DW-1:0] mm [logic [DW-1:0]];

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin
        logic [DW-1:0] rdv;
        logic          inr;
        cyc++;
        if (!rst && cyc + 4 < N) begin
            inr = (mem_addr >> 10) == 0;
            if (mem_r_en) begin
                rdv = (inr && mm.exists(mem_addr)) ? mm[mem_addr] : '0;
                for (int li = 0; li < 3; li++) begin
                    exp_v[li][cyc + lat[li] - 1] = 1'b1;
                    exp_d[li][cyc + lat[li] - 1] = rdv;
                end
            end
            if ((mem_r_en || mem_w_en) && !inr) exp_e[cyc] = 1'b1;
            if (mem_w_en && inr) mm[mem_addr] = mem_w_data;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0 && cyc < N) begin
            for (int li = 0; li < 3; li++) begin
                logic          ev, ee, av, ae;
                logic [DW-1:0] ed, ad;
                case (li)
                    0:       begin av = rv_l1; ad = rd_l1; ae = er_l1; end
                    1:       begin av = rv_l2; ad = rd_l2; ae = er_l2; end
                    default: begin av = rv_l4; ad = rd_l4; ae = er_l4; end
                endcase
                if (rst) begin
                    ev = 1'b0;
                    ee = 1'b0;
                    last_d[li] = '0;
                    for (int k = cyc; k < N; k++) exp_v[li][k] = 1'b0;
                end else begin
                    ev = exp_v[li][cyc];
                    ee = exp_e[cyc];
                    if (ev) last_d[li] = exp_d[li][cyc];
                end
                ed = last_d[li];
                check($sformatf("model L%0d valid", lat[li]), {31'b0, av}, {31'b0, ev});
                check($sformatf("model L%0d data", lat[li]), ad, ed);
                check($sformatf("model L%0d err", lat[li]), {31'b0, ae}, {31'b0, ee});
            end
        end
    end

    task automatic step(input logic r, input logic w, input logic [DW-1:0] a,
                        input logic [DW-1:0] d);
        mem_r_en = r; mem_w_en = w; mem_addr = a; mem_w_data = d;
        @(posedge clk); #2;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0; mem_w_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        check("reset data", rd_l2, '0);
        check("reset valid", {31'b0, rv_l2}, '0);
        check("reset err", {31'b0, er_l2}, '0);
        idle(1);
        rst = 1'b0;

        // Write then read next cycle; valid at +1/+2/+4 per latency.
        step(1'b0, 1'b1, 32'h5, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'h5, '0);
        @(negedge clk);
        check("031 L1 valid +1", {31'b0, rv_l1}, 32'd1);
        check("031 L1 data +1", rd_l1, 32'hDEAD_BEEF);
        check("031 L2 quiet +1", {31'b0, rv_l2}, 32'd0);
        @(negedge clk);
        check("031 L2 valid +2", {31'b0, rv_l2}, 32'd1);
        check("031 L2 data +2", rd_l2, 32'hDEAD_BEEF);
        check("031 L1 hold", rd_l1, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        check("036 L4 valid +4", {31'b0, rv_l4}, 32'd1);
        check("036 L4 data +4", rd_l4, 32'hDEAD_BEEF);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, (i + 1) * 32'h11);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i, '0);
        @(negedge clk);
        check("032 L1 fourth", rd_l1, 32'h44);
        check("032 L2 third", rd_l2, 32'h33);
        check("032 L4 first", rd_l4, 32'h11);
        @(negedge clk);
        check("032 L2 fourth", rd_l2, 32'h44);
        check("032 L2 fourth valid", {31'b0, rv_l2}, 32'd1);
        idle(4);

        // Read-before-write, then read-after-write.
        step(1'b0, 1'b1, 32'h10, 32'hA);
        step(1'b1, 1'b1, 32'h10, 32'hB);
        step(1'b1, 1'b0, 32'h10, '0);
        @(negedge clk);
        check("033 same-cycle old", rd_l2, 32'hA);
        check("033 next-cycle new L1", rd_l1, 32'hB);
        @(negedge clk);
        check("033 next-cycle new L2", rd_l2, 32'hB);
        idle(4);

        // Out-of-range read and write.
        step(1'b1, 1'b0, 32'h400, '0);
        @(negedge clk);
        check("034 rd err +1", {31'b0, er_l2}, 32'd1);
        check("034 L1 valid", {31'b0, rv_l1}, 32'd1);
        check("034 L1 data zero", rd_l1, '0);
        @(negedge clk);
        check("034 L2 valid +2", {31'b0, rv_l2}, 32'd1);
        check("034 L2 data zero", rd_l2, '0);
        check("034 err single", {31'b0, er_l2}, 32'd0);
        step(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF);
        @(negedge clk);
        check("034 wr err +1", {31'b0, er_l1}, 32'd1);
        step(1'b1, 1'b0, 32'h0, '0);
        @(negedge clk);
        check("034 word0 kept", rd_l1, 32'h11);
        step(1'b1, 1'b1, 32'h8000_0005, 32'h1234);
        idle(5);

        // Reset with reads in flight; a write attempted during reset must be dropped.
        step(1'b1, 1'b0, 32'h5, '0);
        rst = 1'b1;
        mem_r_en = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h5; mem_w_data = 32'h0BAD;
        @(negedge clk);
        check("035 rst L1 valid", {31'b0, rv_l1}, 32'd0);
        check("035 rst L1 data", rd_l1, '0);
        idle(1);
        rst = 1'b0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0; mem_w_data = '0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(rv_l1) + int'(rv_l2) + int'(rv_l4);
        end
        check("035 no stale pulse", pulses, 32'd0);
        step(1'b1, 1'b0, 32'h5, '0);
        @(negedge clk);
        check("035 data survives", rd_l1, 32'hDEAD_BEEF);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
